// File: rtl/apple_spawn_ctrl.sv
// apple_spawn_ctrl: detects the snake eating the apple and places a new apple.
// The new apple goes on a pseudo-random cell that is neither the head cell nor,
// optionally, a cell occupied by the snake body.
//   clk, rst           clock, asynchronous active-high reset
//   tick               one-cycle game-step pulse; only honoured in IDLE
//   head_x, head_y     snake head position in pixels (cell-aligned)
//   apple_x, apple_y   current apple position in pixels
//   score              apples eaten plus SCORE_INIT, saturating at 255
//   eat                one-cycle pulse when the head reaches the apple cell
//   busy               high while a new apple is being placed
//   occ_req/occ_x/occ_y/occ_ack/occ_hit  body occupancy query handshake
// Macro BODY_CHECK_EN: when defined, each candidate is checked against the body
// store; when undefined, the occupancy port is tied off and ignored.
module apple_spawn_ctrl #(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 24,
    parameter int CELL       = 20,
    parameter int SCORE_INIT = 2,
    parameter int MAX_TRIES  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [9:0] head_x,
    input  logic [9:0] head_y,
    output logic [9:0] apple_x,
    output logic [9:0] apple_y,
    output logic [7:0] score,
    output logic       eat,
    output logic       busy,
    output logic       occ_req,
    output logic [4:0] occ_x,
    output logic [4:0] occ_y,
    input  logic       occ_ack,
    input  logic       occ_hit
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] GEN   = 3'd2;
    localparam logic [2:0] PROBE = 3'd3;
    localparam logic [2:0] PLACE = 3'd4;
    localparam int TW = $clog2(MAX_TRIES + 1);
`ifdef BODY_CHECK_EN
    localparam bit PROBE_EN = 1'b1;
`else
    localparam bit PROBE_EN = 1'b0;
`endif
    logic [2:0] state;
    logic [15:0] lfsr;
    logic [TW-1:0] tries;
    logic [4:0] cand_x, cand_y, gen_x, gen_y;
    logic [9:0] head_cx, head_cy;
    logic gen_head, at_apple, give_up;
    assign head_cx = head_x / 10'(CELL);
    assign head_cy = head_y / 10'(CELL);
    // Raw 5-bit draws beyond the grid fold back by (32 - size); for 24 rows that is -8.
    assign gen_x = (int'(lfsr[4:0]) >= GRID_W) ? 5'(int'(lfsr[4:0]) - (32 - GRID_W)) : lfsr[4:0];
    assign gen_y = (int'(lfsr[12:8]) >= GRID_H) ? 5'(int'(lfsr[12:8]) - (32 - GRID_H)) : lfsr[12:8];
    assign gen_head = (head_cx == {5'd0, gen_x}) && (head_cy == {5'd0, gen_y});
    assign at_apple = (head_cx == apple_x / 10'(CELL)) && (head_cy == apple_y / 10'(CELL));
    assign give_up = (tries == TW'(MAX_TRIES));
    assign eat = (state == CHECK) && at_apple;
    assign busy = (state == GEN) || (state == PROBE) || (state == PLACE);
`ifdef BODY_CHECK_EN
    assign occ_req = (state == PROBE);
    assign occ_x = cand_x;
    assign occ_y = cand_y;
`else
    logic unused_occ;
    assign unused_occ = occ_ack | occ_hit;
    assign occ_req = 1'b0;
    assign occ_x = 5'd0;
    assign occ_y = 5'd0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lfsr    <= 16'hACE1;
            tries   <= '0;
            cand_x  <= '0;
            cand_y  <= '0;
            score   <= 8'(SCORE_INIT);
            apple_x <= 10'(GRID_W / 2 * CELL);
            apple_y <= 10'(GRID_H / 2 * CELL);
        end else begin
            // Free-running so the draw depends on when the apple is eaten.
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            case (state)
                IDLE: state <= tick ? CHECK : IDLE;
                CHECK: begin
                    if (at_apple) begin
                        score <= (score == 8'hFF) ? score : score + 8'd1;
                        tries <= '0;
                        state <= GEN;
                    end else begin
                        state <= IDLE;
                    end
                end
                GEN: begin
                    cand_x <= gen_x;
                    cand_y <= gen_y;
                    // Once the retry budget is spent the candidate is taken unchecked.
                    if (gen_head && !give_up) tries <= tries + TW'(1);
                    else state <= (give_up || !PROBE_EN) ? PLACE : PROBE;
                end
`ifdef BODY_CHECK_EN
                PROBE: begin
                    if (occ_ack) begin
                        if (occ_hit && tries < TW'(MAX_TRIES)) begin
                            tries <= tries + TW'(1);
                            state <= GEN;
                        end else begin
                            state <= PLACE;
                        end
                    end
                end
`endif
                PLACE: begin
                    apple_x <= 10'(int'(cand_x) * CELL);
                    apple_y <= 10'(int'(cand_y) * CELL);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// tb_apple_spawn_ctrl: directed self-checking bench for apple_spawn_ctrl.
module tb_apple_spawn_ctrl;
`ifdef BODY_CHECK_EN
    localparam bit BODY = 1'b1;
`else
    localparam bit BODY = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, occ_ack = 1'b0, occ_hit = 1'b0;
    logic [9:0] head_x = 10'd0, head_y = 10'd0;
    logic [9:0] apple_x, apple_y, s_apple_x, s_apple_y;
    logic [7:0] score, s_score;
    logic eat, busy, occ_req, s_eat, s_busy, s_occ_req;
    logic [4:0] occ_x, occ_y, s_occ_x, s_occ_y;
    logic [15:0] m_lfsr;
    int checks = 0, errors = 0, exp_score = 2, n_req = 0;

    apple_spawn_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .head_x(head_x), .head_y(head_y),
        .apple_x(apple_x), .apple_y(apple_y), .score(score), .eat(eat), .busy(busy),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit)
    );

    apple_spawn_ctrl #(.SCORE_INIT(255)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .head_x(head_x), .head_y(head_y),
        .apple_x(s_apple_x), .apple_y(s_apple_y), .score(s_score), .eat(s_eat), .busy(s_busy),
        .occ_req(s_occ_req), .occ_x(s_occ_x), .occ_y(s_occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR: equals the DUT LFSR whenever sampled at a falling edge.
    always @(posedge clk or posedge rst) m_lfsr <= rst ? 16'hACE1 : lfsr_step(m_lfsr);

    // Count completed occupancy transactions.
    always @(negedge clk) if (occ_req && occ_ack) n_req <= n_req + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Runs one eat + placement with the head on the apple, starting at a falling edge.
    // Acks each probe one cycle after request; the first nhit acks report a hit.
    task automatic run_eat(input int nhit, output int probes, output int rejects);
        logic [4:0] cx, cy;
        int tries;
        bit done;
        probes = 0; rejects = 0; tries = 0; done = 0; cx = 0; cy = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checks++;
        if (eat !== 1'b1 || s_eat !== 1'b1) begin
            errors++; $display("FAIL eat_pulse: eat=%b sat_eat=%b required 1", eat, s_eat);
        end
        exp_score = (exp_score < 255) ? exp_score + 1 : 255;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || occ_req !== 1'b0) begin
            errors++; $display("FAIL gen_busy: busy=%b occ_req=%b required 1/0", busy, occ_req);
        end
        for (int i = 0; i < 40 && !done; i++) begin
            cx = m_lfsr[4:0];
            cy = (m_lfsr[12:8] >= 5'd24) ? m_lfsr[12:8] - 5'd8 : m_lfsr[12:8];
            if (int'(cx) == int'(head_x) / 20 && int'(cy) == int'(head_y) / 20 && tries < 15) begin
                tries++; rejects++;
                @(negedge clk);
            end else if (tries == 15 || !BODY) begin
                @(negedge clk);
                done = 1;
            end else begin
                @(negedge clk);
                checks++;
                if (occ_req !== 1'b1 || occ_x !== cx || occ_y !== cy) begin
                    errors++;
                    $display("FAIL probe_req: req=%b x=%0d y=%0d required 1 x=%0d y=%0d",
                             occ_req, occ_x, occ_y, cx, cy);
                end
                probes++;
                occ_ack = 1'b1;
                occ_hit = (probes <= nhit);
                @(negedge clk);
                occ_ack = 1'b0;
                if (occ_hit) tries++;
                else done = 1;
                occ_hit = 1'b0;
            end
        end
        if (!done) begin
            errors++; $display("FAIL place_bound: placement never reached");
        end
        @(negedge clk);
        checks++;
        if (apple_x !== 10'(int'(cx) * 20) || apple_y !== 10'(int'(cy) * 20)) begin
            errors++;
            $display("FAIL apple_pos: got (%0d,%0d) required (%0d,%0d)",
                     apple_x, apple_y, int'(cx) * 20, int'(cy) * 20);
        end
        checks++;
        if (busy !== 1'b0 || score !== 8'(exp_score) || s_score !== 8'd255) begin
            errors++;
            $display("FAIL after_place: busy=%b score=%0d sat=%0d required 0/%0d/255",
                     busy, score, s_score, exp_score);
        end
        head_x = 10'(int'(cx) * 20);
        head_y = 10'(int'(cy) * 20);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (apple_x !== 10'd320 || apple_y !== 10'd240 || score !== 8'd2 || s_score !== 8'd255) begin
            errors++;
            $display("FAIL reset_regs: apple=(%0d,%0d) score=%0d sat=%0d required (320,240) 2 255",
                     apple_x, apple_y, score, s_score);
        end
        checks++;
        if (eat !== 1'b0 || busy !== 1'b0 || occ_req !== 1'b0 || occ_x !== 5'd0 || occ_y !== 5'd0) begin
            errors++;
            $display("FAIL reset_outs: eat=%b busy=%b req=%b x=%0d y=%0d required all 0",
                     eat, busy, occ_req, occ_x, occ_y);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_score = 2;
    endtask

    task automatic test_no_eat;
        head_x = 10'd0; head_y = 10'd0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checks++;
        if (eat !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL no_eat_check: eat=%b busy=%b required 0/0", eat, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || score !== 8'd2 || apple_x !== 10'd320 || apple_y !== 10'd240) begin
            errors++;
            $display("FAIL no_eat_idle: busy=%b score=%0d apple=(%0d,%0d) required 0 2 (320,240)",
                     busy, score, apple_x, apple_y);
        end
    endtask

    task automatic test_eat_basic;
        int p, r;
        head_x = 10'd320; head_y = 10'd240;
        run_eat(0, p, r);
        checks++;
        if (score !== 8'd3) begin
            errors++; $display("FAIL first_score: score=%0d required 3", score);
        end
    endtask

    task automatic test_hits;
        int p, r, base;
        base = n_req;
        run_eat(3, p, r);
`ifdef BODY_CHECK_EN
        checks++;
        if (n_req - base !== 4 || p !== 4) begin
            errors++; $display("FAIL hit3_txns: seen=%0d required 4", n_req - base);
        end
`else
        checks++;
        if (n_req - base !== 0) begin
            errors++; $display("FAIL hit3_txns: seen=%0d required 0", n_req - base);
        end
`endif
    endtask

    task automatic test_hit_forever;
        int p, r;
        run_eat(1000, p, r);
`ifdef BODY_CHECK_EN
        checks++;
        if (p + r !== 15) begin
            errors++; $display("FAIL give_up: rejections=%0d required 15", p + r);
        end
`endif
    endtask

    task automatic test_saturate;
        int p, r;
        run_eat(0, p, r);
        checks++;
        if (s_score !== 8'd255 || s_busy !== 1'b0) begin
            errors++; $display("FAIL saturate: score=%0d busy=%b required 255/0", s_score, s_busy);
        end
    endtask

    task automatic test_reset_mid;
        int p, r;
        bit seen;
        seen = !BODY;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = occ_req;
        end
        checks++;
        if (!seen || busy !== 1'b1) begin
            errors++; $display("FAIL mid_reach: in_probe=%b busy=%b required 1/1", seen, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (apple_x !== 10'd320 || apple_y !== 10'd240 || occ_req !== 1'b0 || busy !== 1'b0 || score !== 8'd2) begin
            errors++;
            $display("FAIL mid_reset: apple=(%0d,%0d) req=%b busy=%b score=%0d required (320,240) 0 0 2",
                     apple_x, apple_y, occ_req, busy, score);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_score = 2;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || apple_x !== 10'd320 || apple_y !== 10'd240) begin
            errors++;
            $display("FAIL mid_idle: busy=%b apple=(%0d,%0d) required 0 (320,240)", busy, apple_x, apple_y);
        end
        head_x = 10'd320; head_y = 10'd240;
        run_eat(0, p, r);
        checks++;
        if (score !== 8'd3) begin
            errors++; $display("FAIL mid_recover: score=%0d required 3", score);
        end
    endtask

    initial begin
        test_reset();
        test_no_eat();
        test_eat_basic();
        test_hits();
        test_hit_forever();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
